// File: rtl/bitgen.sv
// bitgen: builds a W-bit word holding min(K, W) one-bits packed at the MSB end.
// A three-state controller (idle / generate / done) shifts ones into R while
// a down-counter C runs from the saturated K to zero, then holds the result
// with Done high until start is released.
module bitgen #(
   parameter int W  = 8,
   parameter int KW = $clog2(W + 1)
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic          LK,
   input  logic          s,
   input  logic [KW-1:0] K,
   output logic [W-1:0]  Data,
   output logic          Done
);

   typedef enum logic [1:0] {
      S1 = 2'b00,
      S2 = 2'b01,
      S3 = 2'b10
   } state_t;

   localparam logic [KW-1:0] W_K = KW'(W);

   state_t        y_q, y_d;
   logic [W-1:0]  r_q, r_d;
   logic [KW-1:0] c_q, c_d;

   logic          z;
   logic          lr;
   logic          er;
   logic          ec;
   logic          lc;
   logic [KW-1:0] k_sat;

   assign z     = (c_q == '0);
   assign k_sat = (K > W_K) ? W_K : K;

   // Controller: next state and enables decode from y and z only; LK gates
   // only the count load, never Done.
   always_comb begin
      y_d  = S1;
      lr   = 1'b0;
      er   = 1'b0;
      ec   = 1'b0;
      lc   = 1'b0;
      Done = 1'b0;
      case (y_q)
         S1: begin
            lr  = 1'b1;
            lc  = LK;
            y_d = s ? S2 : S1;
         end
         S2: begin
            er  = ~z;
            ec  = ~z;
            y_d = z ? S3 : S2;
         end
         S3: begin
            Done = 1'b1;
            y_d  = s ? S3 : S1;
         end
         default: begin
            y_d = S1;
         end
      endcase
   end

   // Datapath next values: clear, shift a one in from the top, load or count down.
   always_comb begin
      r_d = r_q;
      c_d = c_q;
      if (lr) begin
         r_d = '0;
      end else if (er) begin
         r_d = {1'b1, r_q[W-1:1]};
      end
      if (lc) begin
         c_d = k_sat;
      end else if (ec) begin
         c_d = c_q - KW'(1);
      end
   end

   // State and datapath registers; reset aborts any run and clears the word.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         y_q <= S1;
         r_q <= '0;
         c_q <= '0;
      end else begin
         y_q <= y_d;
         r_q <= r_d;
         c_q <= c_d;
      end
   end

   assign Data = r_q;

endmodule
